// File: rtl/gsqrt_nch.sv
// rtl/gsqrt_nch.sv - multi-channel unary square-root generator (saturating up/down counter per lane)
module gsqrt_nch #(
    parameter int BW      = 8,
    parameter int CH      = 4,
    parameter int INIT    = 1 << (BW - 1),
    parameter int FB_MODE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [CH-1:0]      clr,
    input  logic [CH*BW-1:0]   randNum,
    input  logic [CH-1:0]      in,
    output logic [CH-1:0]      out,
    output logic [CH-1:0]      sat
);

    if (BW < 2) begin : g_err_bw
        $error("gsqrt_nch: BW must be >= 2");
    end
    if (CH < 1) begin : g_err_ch
        $error("gsqrt_nch: CH must be >= 1");
    end
    if (INIT < 0 || INIT >= (1 << BW)) begin : g_err_init
        $error("gsqrt_nch: INIT must lie in [0, 2^BW)");
    end

    localparam logic [BW-1:0] INIT_V = INIT[BW-1:0];
    localparam logic [BW-1:0] ONE    = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] MAX    = {BW{1'b1}};

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [BW-1:0] cnt_q;
        logic [BW-1:0] cnt_nxt;
        logic [BW-1:0] rn;
        logic          out_d1_q;
        logic          sat_q;
        logic          dec;

        assign rn     = randNum[i*BW +: BW];
        assign out[i] = (cnt_q > rn);
        assign sat[i] = sat_q;

        // Mode 0 squares the output rate (AND of two successive samples); mode 1 is the legacy XNOR.
        assign dec = (FB_MODE == 0) ? (out[i] & out_d1_q) : ~(out[i] ^ out_d1_q);

        always_comb begin
            cnt_nxt = cnt_q;
            if (en) begin
                if (in[i] && !dec && cnt_q != MAX) begin
                    cnt_nxt = cnt_q + ONE;
                end else if (!in[i] && dec && cnt_q != '0) begin
                    cnt_nxt = cnt_q - ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n || clr[i]) begin
                cnt_q    <= INIT_V;
                out_d1_q <= 1'b0;
                sat_q    <= 1'b0;
            end else begin
                cnt_q <= cnt_nxt;
                if (en) begin
                    out_d1_q <= out[i];
                end
                sat_q <= (cnt_nxt == '0) || (cnt_nxt == MAX);
            end
        end
    end

endmodule

// File: tb/tb_gsqrt_nch.sv
// tb/tb_gsqrt_nch.sv - directed self-checking bench for gsqrt_nch (both feedback modes)
module tb_gsqrt_nch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  clr;
    logic [31:0] rand_num;
    logic [3:0]  in_bits;
    logic [3:0]  out0, out1;
    logic [3:0]  sat0, sat1;

    int n_cmp  = 0;
    int n_fail = 0;

    gsqrt_nch #(.BW(8), .CH(4), .FB_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .randNum(rand_num), .in(in_bits), .out(out0), .sat(sat0)
    );

    gsqrt_nch #(.BW(8), .CH(4), .FB_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .randNum(rand_num), .in(in_bits), .out(out1), .sat(sat1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rn;
        logic [3:0]  exp_out;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Infer each channel count from the comparator: cnt==v iff out(rn=v-1)=1 and out(rn=v)=0.
    task automatic probe(input int which, input logic [31:0] exp_cnt, input string name);
        logic [31:0] save;
        logic [31:0] rn_hi, rn_lo;
        logic [3:0]  exp_hi, got_hi, got_lo;
        save = rand_num;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] e;
            e = exp_cnt[c*8 +: 8];
            rn_hi[c*8 +: 8] = (e == 8'd0) ? 8'd0 : e - 8'd1;
            exp_hi[c]       = (e != 8'd0);
            rn_lo[c*8 +: 8] = e;
        end
        rand_num = rn_hi;
        #1;
        got_hi = (which == 1) ? out1 : out0;
        rand_num = rn_lo;
        #1;
        got_lo = (which == 1) ? out1 : out0;
        rand_num = save;
        #1;
        chk(name, {got_hi, got_lo}, {exp_hi, 4'b0000});
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b1;
        clr      = 4'b0000;
        in_bits  = 4'b0000;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int ones0, ones1;
        rand_num = 32'hFFFF_FFFF;

        // Reset and comparator table: all channels at 128.
        do_reset();
        en = 1'b0;
        chk("reset_sat0", sat0, 4'b0000);
        chk("reset_sat1", sat1, 4'b0000);
        tbl[0] = '{rn: {4{8'd127}}, exp_out: 4'b1111};
        tbl[1] = '{rn: {4{8'd128}}, exp_out: 4'b0000};
        tbl[2] = '{rn: {4{8'd0}},   exp_out: 4'b1111};
        tbl[3] = '{rn: {4{8'd255}}, exp_out: 4'b0000};
        tbl[4] = '{rn: {8'd255, 8'd128, 8'd127, 8'd0}, exp_out: 4'b0011};
        tbl[5] = '{rn: {8'd127, 8'd200, 8'd129, 8'd64}, exp_out: 4'b1001};
        for (int v = 0; v < 6; v++) begin
            rand_num = tbl[v].rn;
            #1;
            chk($sformatf("tbl%0d_out0", v), out0, tbl[v].exp_out);
            chk($sformatf("tbl%0d_out1", v), out1, tbl[v].exp_out);
        end

        // Saturate upward in mode 0; mode 1 holds because steady out gives dec=1.
        do_reset();
        in_bits  = 4'b1111;
        rand_num = {4{8'd255}};
        tick(126);
        probe(0, {4{8'd254}}, "up_254");
        chk("up_sat_pre", sat0, 4'b0000);
        tick(1);
        probe(0, {4{8'd255}}, "up_255");
        chk("up_sat", sat0, 4'b1111);
        probe(1, {4{8'd128}}, "legacy_steady_hold");
        tick(3);
        probe(0, {4{8'd255}}, "up_hold");
        chk("up_sat_hold", sat0, 4'b1111);
        clr = 4'b0100;
        tick(1);
        clr = 4'b0000;
        probe(0, {8'd255, 8'd128, 8'd255, 8'd255}, "clr_sat_cnt");
        chk("clr_sat", sat0, 4'b1011);

        // Saturate downward: no wrap below zero.
        do_reset();
        in_bits  = 4'b0000;
        rand_num = 32'd0;
        tick(128);
        probe(0, {4{8'd1}}, "down_1");
        chk("down_sat_pre", sat0, 4'b0000);
        tick(1);
        probe(0, 32'd0, "down_0");
        chk("down_sat", sat0, 4'b1111);
        chk("down_out", out0, 4'b0000);
        tick(6);
        probe(0, 32'd0, "down_hold");

        // Enable freeze and per-channel clear.
        do_reset();
        in_bits  = 4'b0101;
        rand_num = {4{8'd255}};
        tick(10);
        probe(0, {8'd128, 8'd138, 8'd128, 8'd138}, "ctl_run");
        en = 1'b0;
        tick(10);
        probe(0, {8'd128, 8'd138, 8'd128, 8'd138}, "ctl_frozen");
        en  = 1'b1;
        clr = 4'b0100;
        tick(1);
        probe(0, {8'd128, 8'd128, 8'd128, 8'd139}, "ctl_clr2");
        in_bits = 4'b1111;
        tick(1);
        clr = 4'b0000;
        probe(0, {8'd129, 8'd128, 8'd129, 8'd140}, "ctl_clr_wins");

        // Legacy mode: alternating out gives dec=0 so every in=1 cycle increments.
        do_reset();
        in_bits = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            rand_num = (k % 2 == 1) ? 32'd0 : {4{8'd255}};
            tick(1);
        end
        probe(1, {4{8'd138}}, "legacy_toggle");
        rand_num = {4{8'd255}};
        tick(10);
        probe(1, {4{8'd138}}, "legacy_hold");

        // Convergence: ch0 p=0.25 -> 0.50, ch1 p=0.64 -> 0.80.
        do_reset();
        ones0 = 0;
        ones1 = 0;
        for (int k = 0; k < 16384; k++) begin
            in_bits[0] = ($urandom_range(0, 99) < 25);
            in_bits[1] = ($urandom_range(0, 99) < 64);
            in_bits[3:2] = 2'b00;
            rand_num = $urandom;
            #1;
            ones0 += int'(out0[0]);
            ones1 += int'(out0[1]);
            tick(1);
        end
        chk("conv_p25", (ones0 >= 7700 && ones0 <= 8684) ? 32'd1 : 32'd0, 32'd1);
        chk("conv_p64", (ones1 >= 12616 && ones1 <= 13599) ? 32'd1 : 32'd0, 32'd1);
        if (!(ones0 >= 7700 && ones0 <= 8684) || !(ones1 >= 12616 && ones1 <= 13599))
            $display("conv counts: ch0=%0d ch1=%0d of 16384", ones0, ones1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
